dmaster_st_channel_filter: RTL and testbench

Parametrised Avalon-ST channel adapter that sits between a multi-channel source and a narrower-channel sink on the dmaster byte-stream path. It replaces purely combinational beat-level suppression with packet-aware filtering: the channel is sampled at start-of-packet, and a whole packet is forwarded or dropped. Output is registered through a 2-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`. Dropped packets are counted for debug.

---
 rtl/dmaster_st_pkg.sv | 16 +
 rtl/dmaster_st_skid_buffer.sv | 73 +++++++
 rtl/dmaster_st_channel_filter.sv | 134 +++++++++++++
 tb/tb_dmaster_st_channel_filter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmaster_st_pkg.sv
// Shared definitions for the dmaster byte-stream path: the channel-filter FSM
// state encoding and the parameter-legality check used at elaboration.
package dmaster_st_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } fsm_state_e;

    function automatic bit params_legal(input int in_w, input int out_w, input int max_ch);
        return (out_w >= 1) && (out_w <= in_w) && (out_w <= 30) &&
               (max_ch >= 0) && (max_ch < (32'sd1 <<< out_w));
    endfunction

endpackage

// File: rtl/dmaster_st_skid_buffer.sv
// Two-entry buffer with a registered ready; entry 0 drives the output directly
// so every out_* bit comes straight from a flop.
module dmaster_st_skid_buffer #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [PAYLOAD_W-1:0] push_payload,
    output logic                 push_ready,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic                 valid0_r, valid1_r, ready_r;
    logic [PAYLOAD_W-1:0] entry0_r, entry1_r;
    logic                 valid0_next_s, valid1_next_s, pop_s;
    logic [PAYLOAD_W-1:0] entry0_next_s, entry1_next_s;

    assign pop_s       = valid0_r && out_ready;
    assign push_ready  = ready_r;
    assign out_valid   = valid0_r;
    assign out_payload = entry0_r;

    // Next occupancy and entry contents; entry 1 always shifts toward the head.
    always_comb begin
        valid0_next_s = valid0_r;
        valid1_next_s = valid1_r;
        entry0_next_s = entry0_r;
        entry1_next_s = entry1_r;
        if (push && pop_s) begin
            if (valid1_r) begin
                entry0_next_s = entry1_r;
                entry1_next_s = push_payload;
            end else begin
                entry0_next_s = push_payload;
            end
        end else if (pop_s) begin
            entry0_next_s = entry1_r;
            valid0_next_s = valid1_r;
            valid1_next_s = 1'b0;
        end else if (push) begin
            if (!valid0_r) begin
                entry0_next_s = push_payload;
                valid0_next_s = 1'b1;
            end else begin
                entry1_next_s = push_payload;
                valid1_next_s = 1'b1;
            end
        end else begin
            valid0_next_s = valid0_r;
        end
    end

    // Entry storage plus ready, which is low only while both entries are held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid0_r <= 1'b0;
            valid1_r <= 1'b0;
            ready_r  <= 1'b0;
            entry0_r <= {PAYLOAD_W{1'b0}};
            entry1_r <= {PAYLOAD_W{1'b0}};
        end else begin
            valid0_r <= valid0_next_s;
            valid1_r <= valid1_next_s;
            ready_r  <= !(valid0_next_s && valid1_next_s);
            entry0_r <= entry0_next_s;
            entry1_r <= entry1_next_s;
        end
    end

endmodule

// File: rtl/dmaster_st_channel_filter.sv
// Packet-aware Avalon-ST channel filter: the channel is judged at SOP and the
// whole packet is forwarded or dropped, with drop counting and orphan detection.
module dmaster_st_channel_filter
    import dmaster_st_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int IN_CHANNEL_W  = 8,
    parameter int OUT_CHANNEL_W = 1,
    parameter int MAX_CHANNEL   = 0,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [IN_CHANNEL_W-1:0]  in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [OUT_CHANNEL_W-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     orphan_err,
    input  logic                     stat_clear
);

    localparam int PAYLOAD_W = DATA_W + OUT_CHANNEL_W + 2;

    if (!params_legal(IN_CHANNEL_W, OUT_CHANNEL_W, MAX_CHANNEL)) begin : g_param_check
        $error("dmaster_st_channel_filter: illegal channel parameters");
    end

    fsm_state_e               state_r, state_next_s;
    logic [OUT_CHANNEL_W-1:0] chan_r, chan_next_s;
    logic                     accept_s, chan_ok_s, push_s, drop_inc_s, orphan_set_s;
    logic [PAYLOAD_W-1:0]     push_payload_s, out_payload_s;
    logic [CNT_W-1:0]         drop_count_r;
    logic                     orphan_err_r;

    assign accept_s       = in_valid && in_ready;
    assign chan_ok_s      = (in_channel <= IN_CHANNEL_W'(MAX_CHANNEL));
    assign push_payload_s = {in_data, chan_next_s, in_startofpacket, in_endofpacket};

    // Packet FSM: SOP always restarts the decision; mid-packet channel is ignored.
    always_comb begin
        state_next_s = state_r;
        chan_next_s  = chan_r;
        push_s       = 1'b0;
        drop_inc_s   = 1'b0;
        orphan_set_s = 1'b0;
        if (accept_s) begin
            if (in_startofpacket) begin
                if (chan_ok_s) begin
                    push_s       = 1'b1;
                    chan_next_s  = in_channel[OUT_CHANNEL_W-1:0];
                    state_next_s = in_endofpacket ? ST_IDLE : ST_PASS;
                end else begin
                    drop_inc_s   = 1'b1;
                    state_next_s = in_endofpacket ? ST_IDLE : ST_DROP;
                end
            end else begin
                case (state_r)
                    ST_PASS: begin
                        push_s       = 1'b1;
                        state_next_s = in_endofpacket ? ST_IDLE : ST_PASS;
                    end
                    ST_DROP: begin
                        state_next_s = in_endofpacket ? ST_IDLE : ST_DROP;
                    end
                    ST_IDLE: begin
                        orphan_set_s = 1'b1;
                    end
                    default: begin
                        state_next_s = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state and the channel latched at SOP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            chan_r  <= {OUT_CHANNEL_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            chan_r  <= chan_next_s;
        end
    end

    // Debug statistics; clear wins over a same-cycle increment or set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_r <= {CNT_W{1'b0}};
            orphan_err_r <= 1'b0;
        end else if (stat_clear) begin
            drop_count_r <= {CNT_W{1'b0}};
            orphan_err_r <= 1'b0;
        end else begin
            if (drop_inc_s && (drop_count_r != {CNT_W{1'b1}})) begin
                drop_count_r <= drop_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (orphan_set_s) begin
                orphan_err_r <= 1'b1;
            end
        end
    end

    assign drop_count = drop_count_r;
    assign orphan_err = orphan_err_r;

    dmaster_st_skid_buffer #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push_s),
        .push_payload (push_payload_s),
        .push_ready   (in_ready),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_payload  (out_payload_s)
    );

    assign {out_data, out_channel, out_startofpacket, out_endofpacket} = out_payload_s;

endmodule

// File: tb/tb_dmaster_st_channel_filter.sv
// Directed-vector bench for dmaster_st_channel_filter: a packet table plus
// hand sequences for latency, stats, saturation, backpressure and reset.
module tb_dmaster_st_channel_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, in_valid, in_sop, in_eop, out_ready, stat_clear;
    logic [7:0] in_data, in_channel;
    logic       in_ready, out_valid, out_sop, out_eop, orphan_err;
    logic [7:0] out_data;
    logic [0:0] out_channel;
    logic [15:0] drop_count;
    logic       in_ready_b, out_valid_b, out_sop_b, out_eop_b, orphan_err_b;
    logic [7:0] out_data_b;
    logic [0:0] out_channel_b;
    logic [1:0] drop_count_b;

    dmaster_st_channel_filter dut (
        .clk(clk), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid),
        .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
        .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_channel(out_channel), .out_startofpacket(out_sop),
        .out_endofpacket(out_eop), .drop_count(drop_count), .orphan_err(orphan_err),
        .stat_clear(stat_clear)
    );

    dmaster_st_channel_filter #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in_ready(in_ready_b), .in_valid(in_valid),
        .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
        .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(out_valid_b),
        .out_data(out_data_b), .out_channel(out_channel_b), .out_startofpacket(out_sop_b),
        .out_endofpacket(out_eop_b), .drop_count(drop_count_b), .orphan_err(orphan_err_b),
        .stat_clear(stat_clear)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] ch;
        logic       sop;
        logic       eop;
        logic       clr;
        logic       fwd;
        logic [0:0] exp_ch;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [0:0] ch;
        logic       sop;
        logic       eop;
    } beat_t;

    int    nvec = 0;
    int    nmis = 0;
    int    mode = 0;
    int    push_cnt = 0;
    int    pop_cnt = 0;
    int    stalls = 0;
    beat_t exp_q[$];
    vec_t  tbl[0:19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic [7:0] c, input logic s,
                                input logic e, input logic f, input logic [0:0] ec,
                                input logic clr);
        vec_t v;
        v.data = d; v.ch = c; v.sop = s; v.eop = e; v.fwd = f; v.exp_ch = ec; v.clr = clr;
        return v;
    endfunction

    // Drive one beat, hold it until accepted, and record it if it must come out.
    task automatic send(input vec_t v);
        int t;
        beat_t b;
        @(negedge clk);
        in_valid = 1'b1; in_data = v.data; in_channel = v.ch;
        in_sop = v.sop; in_eop = v.eop; stat_clear = v.clr;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        stalls += t;
        if (t >= 100) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            if (v.fwd) begin
                b.data = v.data; b.ch = v.exp_ch; b.sop = v.sop; b.eop = v.eop;
                exp_q.push_back(b);
                push_cnt++;
            end
        end
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; stat_clear = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    // Output monitor: drives out_ready per mode and checks beats against the queue.
    initial begin
        int cyc;
        logic prev_stall, prev_full, cur_full;
        beat_t prev, e;
        cyc = 0; prev_stall = 1'b0; prev_full = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: out_ready = 1'b0;
            endcase
            if (!reset_n) begin
                prev_stall = 1'b0;
                prev_full  = 1'b0;
            end else begin
                cur_full = ((push_cnt - pop_cnt) == 2);
                if (cur_full && prev_full) check("in_ready_full", in_ready, 32'd0);
                prev_full = cur_full;
                check("valid_vs_occ", out_valid, (push_cnt != pop_cnt));
                if (prev_stall) begin
                    check("stable_data", out_data, prev.data);
                    check("stable_ch", out_channel, prev.ch);
                    check("stable_sop_eop", {out_sop, out_eop}, {prev.sop, prev.eop});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", out_data, 32'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_channel", out_channel, e.ch);
                        check("out_sop", out_sop, e.sop);
                        check("out_eop", out_eop, e.eop);
                    end
                    pop_cnt++;
                end
                prev_stall = out_valid && !out_ready;
                prev.data = out_data; prev.ch = out_channel;
                prev.sop = out_sop; prev.eop = out_eop;
            end
        end
    end

    initial begin
        int bp_stalls;
        reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_channel = 8'h00;
        in_sop = 1'b0; in_eop = 1'b0; stat_clear = 1'b0; out_ready = 1'b1;

        tbl[0]  = mk(8'h11, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[1]  = mk(8'h12, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[2]  = mk(8'h13, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(8'h14, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(8'h21, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(8'h22, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(8'h23, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(8'h24, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(8'h25, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(8'h31, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(8'h32, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(8'h41, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[12] = mk(8'h42, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[13] = mk(8'h43, 8'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[14] = mk(8'h51, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[15] = mk(8'h52, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[16] = mk(8'h53, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[17] = mk(8'h54, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[18] = mk(8'h61, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[19] = mk(8'h71, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 32'd0);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_fields", {out_data, out_channel, out_sop, out_eop}, 32'd0);
        check("rst_stats", {drop_count, orphan_err}, 32'd0);
        @(negedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", in_ready, 32'd1);

        // Table: pass-through, drop, mid-packet channel change, missing EOP
        for (int i = 0; i < 20; i++) send(tbl[i]);
        wait_drain();
        check("table_drop_count", drop_count, 32'd3);
        check("table_orphan", orphan_err, 32'd0);
        check("table_no_stall", stalls, 32'd0);

        // One-cycle latency
        send(mk(8'hA5, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        check("latency_valid", out_valid, 32'd1);
        check("latency_data", out_data, 32'hA5);
        wait_drain();

        // Orphan beat in IDLE
        send(mk(8'h81, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        check("orphan_set", orphan_err, 32'd1);
        check("orphan_drop_count", drop_count, 32'd3);

        // stat_clear together with a drop
        send(mk(8'h90, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        check("clear_drop_count", drop_count, 32'd0);
        check("clear_orphan", orphan_err, 32'd0);
        check("clear_sat_count", drop_count_b, 32'd0);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) send(mk(8'hC0 + 8'(i), 8'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        check("five_drops_wide", drop_count, 32'd5);
        check("five_drops_sat", drop_count_b, 32'd3);
        send(mk(8'hC5, 8'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        check("six_drops_wide", drop_count, 32'd6);
        check("sat_held", drop_count_b, 32'd3);

        // Backpressure with out_ready toggling
        mode = 1;
        stalls = 0;
        for (int i = 0; i < 8; i++)
            send(mk(8'hD1 + 8'(i), 8'd0, (i == 0), (i == 7), 1'b1, 1'b0, 1'b0));
        bp_stalls = stalls;
        wait_drain();
        check("bp_stalled", (bp_stalls > 0), 32'd1);

        // Reset during a buffered, backpressured packet
        #1 mode = 2;
        send(mk(8'hE1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        send(mk(8'hE2, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk); #1;
        check("bp_full_ready", in_ready, 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 32'd0);
        check("midrst_in_ready", in_ready, 32'd0);
        exp_q.delete();
        push_cnt = pop_cnt;
        mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready_back", in_ready, 32'd1);
        repeat (3) @(posedge clk);
        #1 check("midrst_no_partial", out_valid, 32'd0);
        send(mk(8'hF1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        send(mk(8'hF2, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        wait_drain();
        check("midrst_drop_count", drop_count, 32'd0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
